// File: rtl/henad_trace_pkg.sv
// Shared definitions for the henad pipeline trace capture block.
// State encoding and record width helper.
package henad_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int unsigned rec_w(input int unsigned stages,
                                          input int unsigned data_w,
                                          input int unsigned tick_w);
        return tick_w + stages * data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Record storage for the trace buffer: one synchronous write port,
// one asynchronous read port, cleared on reset so reads never return X.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [W-1:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [W-1:0]               rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buf.sv
// Pipeline trace capture: snoops per-stage values into a circular buffer
// with pre/post-trigger windowing, then streams records oldest-first.
module pipe_trace_buf
    import henad_trace_pkg::*;
#(
    parameter int unsigned STAGES     = 8,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TICK_W     = 16,
    parameter int unsigned TRIG_STAGE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         cap_en,
    input  logic                         trig_en,
    input  logic [DATA_W-1:0]            trig_val,
    input  logic [$clog2(DEPTH)-1:0]     post_cnt,
    input  logic [STAGES*DATA_W-1:0]     stage_vec,
    output logic [1:0]                   state,
    output logic                         triggered,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [STAGES*DATA_W-1:0]     rd_data,
    output logic [TICK_W-1:0]            rd_tick,
    output logic                         rd_last
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned VW = STAGES * DATA_W;
    localparam int unsigned RW = rec_w(STAGES, DATA_W, TICK_W);

    state_e          st;
    logic [TICK_W-1:0] tick;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   post_rem;
    logic [RW-1:0]   rd_rec;

    logic            hit;
    logic            we;
    logic            rd_fire;
    logic [CW-1:0]   cnt_inc;
    logic [AW-1:0]   wr_nxt;
    logic [AW-1:0]   rd_entry;

    assign hit      = trig_en & cap_en &
                      (stage_vec[TRIG_STAGE*DATA_W +: DATA_W] == trig_val);
    assign we       = cap_en & ~abort & ((st == ST_PRE) | (st == ST_POST));
    assign cnt_inc  = (count == CW'(DEPTH)) ? count : count + CW'(1);
    assign wr_nxt   = wr_ptr + AW'(1);
    // Oldest record once the capture on this edge has landed.
    assign rd_entry = wr_nxt - AW'(cnt_inc);

    assign state    = st;
    assign rd_valid = (st == ST_DONE) & (count != '0);
    assign rd_last  = rd_valid & (count == CW'(1));
    assign rd_fire  = rd_valid & rd_ready;
    assign rd_data  = rd_rec[VW-1:0];
    assign rd_tick  = rd_rec[RW-1 -: TICK_W];

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr),
        .wdata ({tick, stage_vec}),
        .raddr (rd_ptr),
        .rdata (rd_rec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            tick      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_rem  <= '0;
            count     <= '0;
            triggered <= 1'b0;
        end else begin
            tick <= tick + TICK_W'(1);
            if (abort) begin
                st        <= ST_IDLE;
                count     <= '0;
                triggered <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (arm) begin
                            st        <= ST_PRE;
                            count     <= '0;
                            wr_ptr    <= '0;
                            triggered <= 1'b0;
                        end
                    end
                    ST_PRE: begin
                        if (cap_en) begin
                            wr_ptr <= wr_nxt;
                            count  <= cnt_inc;
                            if (hit) begin
                                triggered <= 1'b1;
                                post_rem  <= post_cnt;
                                if (post_cnt == '0) begin
                                    st     <= ST_DONE;
                                    rd_ptr <= rd_entry;
                                end else begin
                                    st <= ST_POST;
                                end
                            end
                        end
                    end
                    ST_POST: begin
                        if (cap_en) begin
                            wr_ptr <= wr_nxt;
                            count  <= cnt_inc;
                            if (post_rem == AW'(1)) begin
                                st     <= ST_DONE;
                                rd_ptr <= rd_entry;
                            end else begin
                                post_rem <= post_rem - AW'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (rd_fire) begin
                            rd_ptr <= rd_ptr + AW'(1);
                            count  <= count - CW'(1);
                            if (rd_last) begin
                                st        <= ST_IDLE;
                                triggered <= 1'b0;
                            end
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_trace_buf.sv
// Scoreboard bench for pipe_trace_buf: a default instance plus a
// TICK_W=4 instance for stamp wrap-around.
module tb_pipe_trace_buf;

    typedef struct packed {
        logic [23:0] v;
        logic [15:0] t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         arm_a, arm_b, abort, cap_en, trig_en, rd_ready;
    logic [23:0]  trig_val;
    logic [3:0]   post_cnt;
    logic [191:0] stage_vec;

    logic [1:0]   state_a, state_b;
    logic         trig_a, trig_b, rd_valid_a, rd_valid_b, rd_last_a, rd_last_b;
    logic [4:0]   count_a, count_b;
    logic [191:0] rd_data_a, rd_data_b;
    logic [15:0]  rd_tick_a;
    logic [3:0]   rd_tick_b;

    logic         sel;
    logic [1:0]   cur_state;
    logic [4:0]   cur_count;
    logic         cur_valid, cur_last;
    logic [191:0] cur_data;
    logic [15:0]  cur_tick;

    int unsigned  cyc;
    int           total = 0;
    int           bad = 0;
    exp_t         sb[$];

    always #5 clk = ~clk;

    // Free-running cycle model, independent of the DUT stamp.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    pipe_trace_buf u_dut_a (
        .clk(clk), .rst(rst), .arm(arm_a), .abort(abort), .cap_en(cap_en),
        .trig_en(trig_en), .trig_val(trig_val), .post_cnt(post_cnt),
        .stage_vec(stage_vec), .state(state_a), .triggered(trig_a),
        .count(count_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready),
        .rd_data(rd_data_a), .rd_tick(rd_tick_a), .rd_last(rd_last_a)
    );

    pipe_trace_buf #(.TICK_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .arm(arm_b), .abort(abort), .cap_en(cap_en),
        .trig_en(trig_en), .trig_val(trig_val), .post_cnt(post_cnt),
        .stage_vec(stage_vec), .state(state_b), .triggered(trig_b),
        .count(count_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready),
        .rd_data(rd_data_b), .rd_tick(rd_tick_b), .rd_last(rd_last_b)
    );

    assign cur_state = sel ? state_b    : state_a;
    assign cur_count = sel ? count_b    : count_a;
    assign cur_valid = sel ? rd_valid_b : rd_valid_a;
    assign cur_last  = sel ? rd_last_b  : rd_last_a;
    assign cur_data  = sel ? rd_data_b  : rd_data_a;
    assign cur_tick  = sel ? 16'(rd_tick_b) : rd_tick_a;

    function automatic logic [191:0] mkvec(input logic [23:0] v);
        logic [191:0] r;
        for (int s = 0; s < 8; s++) r[s*24 +: 24] = v ^ 24'(s * 24'h111111);
        return r;
    endfunction

    function automatic logic [15:0] exp_tick(input logic [15:0] t);
        return sel ? 16'(t[3:0]) : t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic [23:0] v, input logic expect_cap);
        exp_t e;
        cap_en    = c;
        stage_vec = mkvec(v);
        if (expect_cap) begin
            e.v = v;
            e.t = cyc[15:0];
            sb.push_back(e);
            if (sb.size() > 16) void'(sb.pop_front());
        end
        step();
        cap_en = 1'b0;
    endtask

    task automatic arm_it(input logic b);
        sel = b;
        if (b) arm_b = 1'b1;
        else   arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        arm_b = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string nm);
        int guard = 0;
        exp_t e;
        rd_ready = 1'b1;
        while (cur_valid && guard < 40) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL %s extra: got record %h want none", nm, cur_data[23:0]);
            end else begin
                e = sb.pop_front();
                total++;
                if (cur_data !== mkvec(e.v)) begin
                    bad++;
                    $display("FAIL %s data: got %h want %h", nm, cur_data[23:0], e.v);
                end
                total++;
                if (cur_tick !== exp_tick(e.t)) begin
                    bad++;
                    $display("FAIL %s tick: got %h want %h", nm, cur_tick, exp_tick(e.t));
                end
                total++;
                if (cur_last !== 1'(sb.size() == 0)) begin
                    bad++;
                    $display("FAIL %s last: got %b want %b", nm, cur_last, sb.size() == 0);
                end
            end
            step();
            guard++;
        end
        rd_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s missing: got %0d left want 0", nm, sb.size());
        end
        total++;
        if (cur_state !== 2'd0) begin
            bad++;
            $display("FAIL %s end_state: got %0d want 0", nm, cur_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++;
        if (state_a !== 2'd0 || count_a !== 5'd0 || rd_valid_a !== 1'b0 ||
            trig_a !== 1'b0 || rd_last_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: got st=%0d cnt=%0d v=%b t=%b l=%b want 0s",
                     state_a, count_a, rd_valid_a, trig_a, rd_last_a);
        end
        total++;
        if (state_b !== 2'd0 || count_b !== 5'd0 || rd_valid_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got st=%0d cnt=%0d v=%b want 0s", state_b, count_b, rd_valid_b);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        trig_val = 24'h12; post_cnt = 4'd2;
        arm_it(1'b0);
        total++;
        if (state_a !== 2'd1 || count_a !== 5'd0) begin
            bad++;
            $display("FAIL basic_arm: got st=%0d cnt=%0d want 1 0", state_a, count_a);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 24'(24'h10 + i), 1'b1);
            if (i == 2) begin
                total++;
                if (state_a !== 2'd2 || trig_a !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_trig: got st=%0d trig=%b want 2 1", state_a, trig_a);
                end
            end
        end
        total++;
        if (state_a !== 2'd3 || count_a !== 5'd5) begin
            bad++;
            $display("FAIL basic_done: got st=%0d cnt=%0d want 3 5", state_a, count_a);
        end
        drain("basic");
    endtask

    task automatic test_wrap();
        trig_val = 24'd40; post_cnt = 4'd3;
        arm_it(1'b0);
        for (int n = 0; n < 44; n++) drive(1'b1, 24'(n), 1'b1);
        total++;
        if (state_a !== 2'd3 || count_a !== 5'd16) begin
            bad++;
            $display("FAIL wrap_done: got st=%0d cnt=%0d want 3 16", state_a, count_a);
        end
        drain("wrap");
    endtask

    task automatic test_cap_gaps();
        trig_val = 24'h55; post_cnt = 4'd2;
        arm_it(1'b0);
        drive(1'b1, 24'h50, 1'b1);
        drive(1'b1, 24'h55, 1'b1);
        drive(1'b1, 24'h56, 1'b1);
        drive(1'b0, 24'h57, 1'b0);
        total++;
        if (state_a !== 2'd2 || count_a !== 5'd3) begin
            bad++;
            $display("FAIL gap_hold: got st=%0d cnt=%0d want 2 3", state_a, count_a);
        end
        drive(1'b1, 24'h58, 1'b1);
        drive(1'b0, 24'h59, 1'b0);
        total++;
        if (state_a !== 2'd3 || count_a !== 5'd4) begin
            bad++;
            $display("FAIL gap_done: got st=%0d cnt=%0d want 3 4", state_a, count_a);
        end
        drain("gaps");
    endtask

    task automatic test_hold();
        trig_val = 24'h72; post_cnt = 4'd0;
        arm_it(1'b0);
        drive(1'b1, 24'h70, 1'b1);
        drive(1'b1, 24'h71, 1'b1);
        drive(1'b1, 24'h72, 1'b1);
        total++;
        if (state_a !== 2'd3 || trig_a !== 1'b1) begin
            bad++;
            $display("FAIL hold_done: got st=%0d trig=%b want 3 1", state_a, trig_a);
        end
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== mkvec(sb[0].v) || rd_tick_a !== sb[0].t) begin
                bad++;
                $display("FAIL hold_stable: got v=%b d=%h t=%h want 1 %h %h",
                         rd_valid_a, rd_data_a[23:0], rd_tick_a, sb[0].v, sb[0].t);
            end
            step();
        end
        drain("hold");
    endtask

    task automatic test_abort_rst();
        trig_val = 24'h80; post_cnt = 4'd5;
        arm_it(1'b0);
        drive(1'b1, 24'h80, 1'b1);
        drive(1'b1, 24'h81, 1'b1);
        total++;
        if (state_a !== 2'd2) begin
            bad++;
            $display("FAIL abort_pre: got st=%0d want 2", state_a);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (state_a !== 2'd0 || count_a !== 5'd0 || rd_valid_a !== 1'b0 || trig_a !== 1'b0) begin
            bad++;
            $display("FAIL abort: got st=%0d cnt=%0d v=%b t=%b want 0s",
                     state_a, count_a, rd_valid_a, trig_a);
        end
        trig_val = 24'h90; post_cnt = 4'd0;
        arm_it(1'b0);
        drive(1'b1, 24'h8F, 1'b1);
        drive(1'b1, 24'h90, 1'b1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (state_a !== 2'd0 || count_a !== 5'd0 || rd_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got st=%0d cnt=%0d v=%b want 0s", state_a, count_a, rd_valid_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        trig_val = 24'hA2; post_cnt = 4'd1;
        arm_it(1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 24'(24'hA0 + i), 1'b1);
        total++;
        if (state_a !== 2'd3 || count_a !== 5'd4) begin
            bad++;
            $display("FAIL rearm_done: got st=%0d cnt=%0d want 3 4", state_a, count_a);
        end
        drain("rearm");
    endtask

    task automatic test_tick_wrap();
        trig_val = 24'd20; post_cnt = 4'd3;
        arm_it(1'b1);
        for (int n = 0; n < 24; n++) drive(1'b1, 24'(n), 1'b1);
        total++;
        if (state_b !== 2'd3 || count_b !== 5'd16 || state_a !== 2'd0) begin
            bad++;
            $display("FAIL tickw_done: got st=%0d cnt=%0d a_st=%0d want 3 16 0",
                     state_b, count_b, state_a);
        end
        drain("tickwrap");
        sel = 1'b0;
    endtask

    initial begin
        arm_a = 0; arm_b = 0; abort = 0; cap_en = 0; trig_en = 1; rd_ready = 0;
        trig_val = '0; post_cnt = '0; stage_vec = '0; sel = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_cap_gaps();
        test_hold();
        test_abort_rst();
        test_tick_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
